// File: rtl/midi_tx.sv
// midi_tx: MIDI serial transmitter.
// Accepts note-on/note-off events over a valid/ready handshake, queues them in
// a 4-entry FIFO, and sends each one as a MIDI channel message on an 8N1 UART
// line. The message is 3 bytes, or 2 bytes when the status byte is dropped
// under running status.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-low reset
//   ev_valid  event present
//   ev_ready  FIFO can take an event (not full)
//   ev_on     1 = note-on (0x9n), 0 = note-off (0x8n)
//   ev_note   MIDI note number
//   ev_vel    velocity
//   midi_out  registered serial line, idles high
//   busy      FIFO non-empty or a message in progress
//   msg_done  one-cycle pulse after the last stop bit of a message
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for a queued event
// LOAD  | popped event latched; choose the first byte (running status)
// START | start bit (low) for one bit time
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); then next byte, next message, or idle
module midi_tx #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 31_250,
    parameter int CHANNEL        = 0,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_on,
    input  logic [6:0] ev_note,
    input  logic [6:0] ev_vel,
    output logic       midi_out,
    output logic       busy,
    output logic       msg_done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [3:0] CH = 4'(CHANNEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t state, state_next;

    // FIFO of {on, note, vel}
    logic [14:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        full, empty, push, pop;
    logic [14:0] fifo_rd;

    // current message
    logic        cur_on;
    logic [6:0]  cur_note, cur_vel;
    logic [7:0]  last_status;
    logic [7:0]  status_byte;
    logic [1:0]  byte_idx;
    logic        last_byte;
    logic [7:0]  cur_byte;

    // bit timing
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_next;
    logic              tick;
    logic              done_now;
    logic              out_next;

    assign full     = (count == 3'd4);
    assign empty    = (count == 3'd0);
    assign ev_ready = !full;
    assign push     = ev_valid && !full;
    assign fifo_rd  = fifo_mem[rd_ptr];

    assign tick        = (baud == BAUD_LAST);
    assign status_byte = {1'b1, 2'b00, cur_on, CH};
    assign last_byte   = (byte_idx == 2'd2);

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = status_byte;
            2'd1:    cur_byte = {1'b0, cur_note};
            default: cur_byte = {1'b0, cur_vel};
        endcase
    end

    // FIFO storage has no reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ev_on, ev_note, ev_vel};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done_now   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_START;
            end
            S_START: begin
                if (tick) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (tick && bit_cnt == 3'd7) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!last_byte) begin
                        state_next = S_START;
                    end else begin
                        done_now = 1'b1;
                        if (!empty) begin
                            pop        = 1'b1;
                            state_next = S_LOAD;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The line level is computed for the state being entered so that the
    // registered output changes on the same edge as the state.
    always_comb begin
        out_next = 1'b1;
        bit_next = 3'd0;
        if (state == S_DATA) begin
            bit_next = tick ? (bit_cnt + 3'd1) : bit_cnt;
        end
        case (state_next)
            S_START: out_next = 1'b0;
            S_DATA:  out_next = cur_byte[bit_next];
            default: out_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            midi_out    <= 1'b1;
            msg_done    <= 1'b0;
            busy        <= 1'b0;
            baud        <= '0;
            bit_cnt     <= 3'd0;
            byte_idx    <= 2'd0;
            last_status <= 8'h00;
            cur_on      <= 1'b0;
            cur_note    <= 7'd0;
            cur_vel     <= 7'd0;
        end else begin
            midi_out <= out_next;
            msg_done <= done_now;
            busy     <= !empty || (state != S_IDLE);

            if (pop) begin
                {cur_on, cur_note, cur_vel} <= fifo_rd;
            end

            if (state == S_START || state == S_DATA || state == S_STOP) begin
                baud <= tick ? '0 : baud + BAUD_W'(1);
            end else begin
                baud <= '0;
            end

            if (state == S_DATA) begin
                if (tick) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                bit_cnt <= 3'd0;
            end

            if (state == S_LOAD) begin
                // last_status resets to 0x00, which no status byte can equal
                if (RUNNING_STATUS != 0 && status_byte == last_status) begin
                    byte_idx <= 2'd1;
                end else begin
                    byte_idx <= 2'd0;
                end
                last_status <= status_byte;
            end else if (state == S_STOP && tick && !last_byte) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed bench for midi_tx at 10 clocks per bit.
// u_dut0: channel 0, running status on. u_dut1: channel 5, running status off.
module tb_midi_tx;

    localparam int CLK_HZ = 312_500;   // 312500 / 31250 = 10 clocks per bit

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] ev_valid;
    logic [1:0] ev_on;
    logic [6:0] ev_note [2];
    logic [6:0] ev_vel  [2];
    logic [1:0] ev_ready;
    logic [1:0] midi_out;
    logic [1:0] busy;
    logic [1:0] msg_done;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    logic       bp_on   [6];
    logic [6:0] bp_note [6];
    logic [6:0] bp_vel  [6];
    int         bp_n    [6];
    logic [7:0] bp_b    [6][3];

    midi_tx #(
        .CLK_FREQ(CLK_HZ), .BAUD_RATE(31_250), .CHANNEL(0), .RUNNING_STATUS(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .ev_valid(ev_valid[0]), .ev_ready(ev_ready[0]),
        .ev_on(ev_on[0]), .ev_note(ev_note[0]), .ev_vel(ev_vel[0]),
        .midi_out(midi_out[0]), .busy(busy[0]), .msg_done(msg_done[0])
    );

    midi_tx #(
        .CLK_FREQ(CLK_HZ), .BAUD_RATE(31_250), .CHANNEL(5), .RUNNING_STATUS(0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .ev_valid(ev_valid[1]), .ev_ready(ev_ready[1]),
        .ev_on(ev_on[1]), .ev_note(ev_note[1]), .ev_vel(ev_vel[1]),
        .midi_out(midi_out[1]), .busy(busy[1]), .msg_done(msg_done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send(input int d, input logic on, input logic [6:0] note,
                        input logic [6:0] vel, output int t_acc);
        int w;
        @(negedge clk);
        ev_on[d]    = on;
        ev_note[d]  = note;
        ev_vel[d]   = vel;
        ev_valid[d] = 1'b1;
        w = 0;
        while (!ev_ready[d] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) chk("send_ready", ev_ready[d], 1);
        @(posedge clk);
        #1;
        t_acc       = cyc;
        ev_valid[d] = 1'b0;
    endtask

    // Called at a negedge; samples every bit in its middle.
    task automatic rx_byte(input int d, output logic [7:0] b, output int t_start);
        int w;
        b       = 8'h00;
        t_start = -1;
        w       = 0;
        while (midi_out[d] != 1'b0 && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (w >= 600) begin
            chk("rx_start", midi_out[d], 0);
            return;
        end
        t_start = cyc;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b[i] = midi_out[d];
            if (i < 7) repeat (10) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("stop_bit", midi_out[d], 1);
    endtask

    task automatic expect_msg(input int d, input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input int exp_start, output int t_first, output int t_done);
        logic [7:0] exp_b [3];
        logic [7:0] got;
        int ts;
        int w;
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
        t_first  = -1;
        t_done   = -1;
        for (int i = 0; i < n; i++) begin
            rx_byte(d, got, ts);
            if (i == 0) begin
                t_first = ts;
                if (exp_start >= 0) chk("msg_start", ts, exp_start);
            end else begin
                chk("byte_spacing", ts, t_first + 100 * i);
            end
            chk($sformatf("dut%0d_byte%0d", d, i), got, exp_b[i]);
        end
        w = 0;
        while (w < 60) begin
            @(negedge clk);
            if (msg_done[d]) break;
            w++;
        end
        if (w >= 60) chk("msg_done_seen", msg_done[d], 1);
        t_done = cyc;
        chk("msg_done_time", cyc, t_first + 100 * n);
        @(negedge clk);
        chk("msg_done_width", msg_done[d], 0);
    endtask

    initial begin
        int ta, tb, tf, td;
        int acc [6];
        int tfirst [6];
        int tdone [6];
        int lows, dones, busys;

        ev_valid = 2'b00;
        ev_on    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ev_note[i] = 7'd0;
            ev_vel[i]  = 7'd0;
        end

        bp_on[0] = 1'b1; bp_note[0] = 7'd60; bp_vel[0] = 7'd100; bp_n[0] = 3;
        bp_b[0][0] = 8'h90; bp_b[0][1] = 8'h3C; bp_b[0][2] = 8'h64;
        bp_on[1] = 1'b1; bp_note[1] = 7'd62; bp_vel[1] = 7'd101; bp_n[1] = 2;
        bp_b[1][0] = 8'h3E; bp_b[1][1] = 8'h65; bp_b[1][2] = 8'h00;
        bp_on[2] = 1'b0; bp_note[2] = 7'd62; bp_vel[2] = 7'd0;   bp_n[2] = 3;
        bp_b[2][0] = 8'h80; bp_b[2][1] = 8'h3E; bp_b[2][2] = 8'h00;
        bp_on[3] = 1'b0; bp_note[3] = 7'd64; bp_vel[3] = 7'd5;   bp_n[3] = 2;
        bp_b[3][0] = 8'h40; bp_b[3][1] = 8'h05; bp_b[3][2] = 8'h00;
        bp_on[4] = 1'b1; bp_note[4] = 7'd65; bp_vel[4] = 7'd127; bp_n[4] = 3;
        bp_b[4][0] = 8'h90; bp_b[4][1] = 8'h41; bp_b[4][2] = 8'h7F;
        bp_on[5] = 1'b1; bp_note[5] = 7'd67; bp_vel[5] = 7'd1;   bp_n[5] = 2;
        bp_b[5][0] = 8'h43; bp_b[5][1] = 8'h01; bp_b[5][2] = 8'h00;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_midi_out", midi_out[0], 1);
        chk("rst_ev_ready", ev_ready[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_msg_done", msg_done[0], 0);
        chk("rst_midi_out1", midi_out[1], 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single event: latency, bytes, timing, busy
        send(0, 1'b1, 7'd60, 7'd100, ta);
        @(negedge clk);
        chk("busy_accept_cycle", busy[0], 0);
        @(negedge clk);
        chk("line_cycle1", midi_out[0], 1);
        chk("busy_rise", busy[0], 1);
        expect_msg(0, 3, 8'h90, 8'h3C, 8'h64, ta + 2, tf, td);
        chk("busy_after_done", busy[0], 0);

        // running status: same status byte is dropped
        send(0, 1'b1, 7'd64, 7'd90, ta);
        expect_msg(0, 2, 8'h40, 8'h5A, 8'h00, ta + 2, tf, td);

        // status change to note-off
        send(0, 1'b0, 7'd60, 7'd0, ta);
        expect_msg(0, 3, 8'h80, 8'h3C, 8'h00, ta + 2, tf, td);

        // channel 5, running status disabled
        send(1, 1'b1, 7'd60, 7'd100, ta);
        expect_msg(1, 3, 8'h95, 8'h3C, 8'h64, ta + 2, tf, td);
        send(1, 1'b1, 7'd64, 7'd90, ta);
        expect_msg(1, 3, 8'h95, 8'h40, 8'h5A, ta + 2, tf, td);
        send(1, 1'b0, 7'd60, 7'd0, ta);
        expect_msg(1, 3, 8'h85, 8'h3C, 8'h00, ta + 2, tf, td);

        // back-pressure: 6 events with ev_valid held high
        fork
            begin : stim
                int w;
                @(negedge clk);
                ev_valid[0] = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    ev_on[0]   = bp_on[k];
                    ev_note[0] = bp_note[k];
                    ev_vel[0]  = bp_vel[k];
                    w = 0;
                    while (!ev_ready[0] && w < 2000) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 2000) chk("bp_ready", ev_ready[0], 1);
                    @(posedge clk);
                    #1;
                    acc[k] = cyc;
                    if (k == 4) chk("ready_low_edge5", ev_ready[0], 0);
                end
                ev_valid[0] = 1'b0;
            end
            begin : rx
                for (int m = 0; m < 6; m++) begin
                    expect_msg(0, bp_n[m], bp_b[m][0], bp_b[m][1], bp_b[m][2],
                               (m == 0) ? -1 : tdone[m-1] + 1, tfirst[m], tdone[m]);
                end
            end
        join
        for (int k = 1; k < 5; k++) chk($sformatf("bp_accept%0d", k), acc[k], acc[0] + k);
        chk("bp_first_start", tfirst[0], acc[0] + 2);
        chk("bp_sixth_accept", acc[5], tdone[0] + 1);

        // async reset mid-DATA of the second byte, with one event queued
        send(0, 1'b1, 7'd60, 7'd100, ta);
        send(0, 1'b0, 7'd50, 7'd50, tb);
        while (cyc < ta + 127) @(negedge clk);
        chk("pre_reset_low", midi_out[0], 0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_line", midi_out[0], 1);
        chk("async_rst_busy", busy[0], 0);
        chk("async_rst_ready", ev_ready[0], 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        lows = 0; dones = 0; busys = 0;
        repeat (400) begin
            @(negedge clk);
            if (midi_out[0] == 1'b0) lows++;
            if (msg_done[0]) dones++;
            if (busy[0]) busys++;
        end
        chk("post_rst_line_lows", lows, 0);
        chk("post_rst_msg_done", dones, 0);
        chk("post_rst_busy", busys, 0);
        send(0, 1'b1, 7'd60, 7'd100, ta);
        expect_msg(0, 3, 8'h90, 8'h3C, 8'h64, ta + 2, tf, td);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
